// File: rtl/apb_pkg.sv
// Shared types, offsets and address decode for the APB register completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } apb_state_t;

   localparam logic [31:0] ID_OFS       = 32'h0000_0000;
   localparam logic [31:0] CTRL_OFS     = 32'h0000_0004;
   localparam logic [31:0] ID_VALUE_DEF = 32'hA5B0_0001;

   // Misaligned, beyond the register bank, or a write to the read-only ID.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic        write,
                                     input int          num_regs);
      logic [33:0] lim;
      lim = 34'(num_regs) << 2;
      return (addr[1:0] != 2'b00) || ({2'b00, addr} >= lim) ||
             (write && (addr == ID_OFS));
   endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Word register array with a read-only ID at index 0 and CTRL exported.
// Writes land on the clock edge when we=1; the read mux is combinational.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int          NUM_REGS   = 8,
   parameter int          IDXW       = 3,
   parameter logic [31:0] ID_VALUE   = ID_VALUE_DEF,
   parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [IDXW-1:0] idx,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic [31:0]     ctrl
);

   localparam int ID_IDX   = int'(ID_OFS >> 2);
   localparam int CTRL_IDX = int'(CTRL_OFS >> 2);

   logic [31:0] regs [1:NUM_REGS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++)
            regs[i] <= (i == CTRL_IDX) ? CTRL_RESET : 32'h0;
      end else if (we) begin
         for (int i = 1; i < NUM_REGS; i++)
            if (idx == IDXW'(i))
               regs[i] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (idx == IDXW'(ID_IDX))
         rdata = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++)
         if (idx == IDXW'(i))
            rdata = regs[i];
   end

   assign ctrl = regs[CTRL_IDX];

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer: setup-captured decode, WAIT_CYCLES PREADY-low cycles then one
// registered completion cycle; PSEL dropping mid-transfer aborts without a write.
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF,
   parameter logic [31:0] CTRL_RESET  = 32'h0000_0000
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] ctrl_o
);

   localparam int IDXW = $clog2(NUM_REGS);

   apb_state_t      state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [IDXW-1:0] cap_idx, cap_idx_nxt;
   logic            cap_write, cap_write_nxt;
   logic            cap_err, cap_err_nxt;
   logic [31:0]     cap_wdata, cap_wdata_nxt;
   logic            pready_nxt, pslverr_nxt;
   logic [31:0]     prdata_nxt;

   logic            enter_done;
   logic            bank_we;
   logic [IDXW-1:0] sel_idx;
   logic            sel_write, sel_err, live_err;
   logic [31:0]     bank_rdata;

   apb_reg_bank #(
      .NUM_REGS   (NUM_REGS),
      .IDXW       (IDXW),
      .ID_VALUE   (ID_VALUE),
      .CTRL_RESET (CTRL_RESET)
   ) u_bank (
      .clk   (PCLK),
      .rst   (PRESET),
      .we    (bank_we),
      .idx   (sel_idx),
      .wdata (cap_wdata),
      .rdata (bank_rdata),
      .ctrl  (ctrl_o)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_idx   <= '0;
         cap_write <= 1'b0;
         cap_err   <= 1'b0;
         cap_wdata <= '0;
         PREADY    <= 1'b0;
         PSLVERR   <= 1'b0;
         PRDATA    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cap_idx   <= cap_idx_nxt;
         cap_write <= cap_write_nxt;
         cap_err   <= cap_err_nxt;
         cap_wdata <= cap_wdata_nxt;
         PREADY    <= pready_nxt;
         PSLVERR   <= pslverr_nxt;
         PRDATA    <= prdata_nxt;
      end
   end

   // In IDLE with WAIT_CYCLES=0 the response is built straight from the live bus.
   assign live_err  = addr_err(PADDR, PWRITE, NUM_REGS);
   assign sel_idx   = (state == IDLE) ? PADDR[IDXW+1:2] : cap_idx;
   assign sel_write = (state == IDLE) ? PWRITE : cap_write;
   assign sel_err   = (state == IDLE) ? live_err : cap_err;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cap_idx_nxt   = cap_idx;
      cap_write_nxt = cap_write;
      cap_err_nxt   = cap_err;
      cap_wdata_nxt = cap_wdata;
      enter_done    = 1'b0;
      bank_we       = 1'b0;

      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               cap_idx_nxt   = PADDR[IDXW+1:2];
               cap_write_nxt = PWRITE;
               cap_err_nxt   = live_err;
               cap_wdata_nxt = PWDATA;
               cnt_nxt       = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_nxt  = WAIT;
               end
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_nxt = IDLE;
            end else if (PENABLE) begin
               if (cnt == 4'd1) begin
                  state_nxt  = DONE;
                  enter_done = 1'b1;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            bank_we   = PSEL && cap_write && !cap_err;
         end
         default: state_nxt = IDLE;
      endcase

      pready_nxt  = enter_done;
      pslverr_nxt = enter_done && sel_err;
      prdata_nxt  = (enter_done && !sel_write && !sel_err) ? bank_rdata : 32'h0;
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: dut_a uses 2 wait states, dut_b zero wait states; PSEL picks one.
module tb_apb_reg_slave;
   import apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel_a, psel_b, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata_a, prdata_b, ctrl_a, ctrl_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;
   logic        zw;
   logic [31:0] obs_rdata;
   logic        obs_ready, obs_slverr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   apb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(2)) dut_a (
      .PCLK(clk), .PRESET(rst), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
      .PSLVERR(pslverr_a), .ctrl_o(ctrl_a)
   );

   apb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(0)) dut_b (
      .PCLK(clk), .PRESET(rst), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
      .PSLVERR(pslverr_b), .ctrl_o(ctrl_b)
   );

   assign obs_rdata  = zw ? prdata_b  : prdata_a;
   assign obs_ready  = zw ? pready_b  : pready_a;
   assign obs_slverr = zw ? pslverr_b : pslverr_a;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full transfer; the bus is scrambled during ACCESS to prove setup capture.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int cyc);
      @(negedge clk);
      psel_a = !zw; psel_b = zw; penable = 1'b0;
      paddr = addr; pwrite = wr; pwdata = wd;
      @(negedge clk);
      penable = 1'b1; paddr = addr ^ 32'h10; pwrite = !wr; pwdata = ~wd;
      cyc = 0; rd = '0; err = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge clk);
         if (obs_ready) begin
            cyc = n; rd = obs_rdata; err = obs_slverr;
            break;
         end
         chk("prdata_wait", obs_rdata, 32'h0);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      int          cyc;

      zw = 1'b0; rst = 1'b1;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pready", 32'(pready_a), 32'h0);
      chk("rst_pslverr", 32'(pslverr_a), 32'h0);
      chk("rst_prdata", prdata_a, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_ctrl", ctrl_a, 32'h0);

      xfer(32'h0, 1'b0, 32'h0, rd, err, cyc);
      chk("id_rdata", rd, 32'hA5B0_0001);
      chk("id_err", 32'(err), 32'h0);
      chk("id_cycle", 32'(cyc), 32'd3);

      xfer(32'h4, 1'b1, 32'hDEAD_BEEF, rd, err, cyc);
      chk("wr_ctrl_cycle", 32'(cyc), 32'd3);
      chk("wr_ctrl_err", 32'(err), 32'h0);
      chk("ctrl_in_completion", ctrl_a, 32'h0);
      idle();
      chk("ctrl_after", ctrl_a, 32'hDEAD_BEEF);

      xfer(32'h4, 1'b0, 32'h0, rd, err, cyc);
      chk("rd_ctrl", rd, 32'hDEAD_BEEF);
      chk("rd_ctrl_cycle", 32'(cyc), 32'd3);

      xfer(32'h0, 1'b1, 32'h1234_5678, rd, err, cyc);
      chk("wr_id_err", 32'(err), 32'h1);
      chk("wr_id_cycle", 32'(cyc), 32'd3);
      xfer(32'h0, 1'b0, 32'h0, rd, err, cyc);
      chk("id_after_wr", rd, 32'hA5B0_0001);
      chk("id_after_wr_err", 32'(err), 32'h0);

      xfer(32'h20, 1'b0, 32'h0, rd, err, cyc);
      chk("oor_err", 32'(err), 32'h1);
      chk("oor_rdata", rd, 32'h0);
      chk("oor_cycle", 32'(cyc), 32'd3);

      xfer(32'h6, 1'b0, 32'h0, rd, err, cyc);
      chk("mis_err", 32'(err), 32'h1);
      chk("mis_rdata", rd, 32'h0);

      // Abort: PSEL drops during A1 of a write to 0xC.
      @(negedge clk);
      psel_a = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h55;
      @(negedge clk);
      psel_a = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("abort_pready", 32'(pready_a), 32'h0);
      end
      xfer(32'hC, 1'b0, 32'h0, rd, err, cyc);
      chk("abort_rd", rd, 32'h0);
      chk("abort_rd_err", 32'(err), 32'h0);

      // Reset in A2 of a write to CTRL.
      @(negedge clk);
      psel_a = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h77;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_a2_pready", 32'(pready_a), 32'h0);
      chk("rst_a2_ctrl", ctrl_a, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk("penable_idle_pready", 32'(pready_a), 32'h0);
      end
      idle();
      chk("rst_a2_ctrl_later", ctrl_a, 32'h0);

      // Reset during the completion cycle drops PREADY immediately and the write.
      @(negedge clk);
      psel_a = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h99;
      @(negedge clk);
      penable = 1'b1;
      repeat (2) @(negedge clk);
      chk("a3_pready", 32'(pready_a), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_a3_pready", 32'(pready_a), 32'h0);
      @(negedge clk);
      rst = 1'b0; psel_a = 1'b0; penable = 1'b0;
      xfer(32'h10, 1'b0, 32'h0, rd, err, cyc);
      chk("rst_a3_dropped", rd, 32'h0);

      // Zero wait states, back-to-back.
      idle();
      zw = 1'b1;
      xfer(32'h8, 1'b1, 32'h11, rd, err, cyc);
      chk("zw_wr_cycle", 32'(cyc), 32'd1);
      chk("zw_wr_err", 32'(err), 32'h0);
      xfer(32'h8, 1'b0, 32'h0, rd, err, cyc);
      chk("zw_rd_cycle", 32'(cyc), 32'd1);
      chk("zw_rd", rd, 32'h11);
      xfer(32'h24, 1'b0, 32'h0, rd, err, cyc);
      chk("zw_oor_err", 32'(err), 32'h1);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
